// File: rtl/conditioner_pkg.sv
// Shared definitions for the multi-channel input conditioner: edge-mode
// encodings, counter sizing helper and edge qualification.
package conditioner_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned w = 0; w < 32; w++) begin
      if ((64'(1) << w) < 64'(value)) width = w + 1;
    end
    return width;
  endfunction

  // True when a level change to new_level is reportable under mode.
  function automatic logic edge_qualifies(input logic [1:0] mode, input logic new_level);
    case (mode)
      EDGE_RISE: return new_level;
      EDGE_FALL: return !new_level;
      EDGE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/conditioner_channel.sv
// One conditioner channel: synchroniser chain, stable-count glitch filter,
// mode-qualified edge pulse and host-clearable sticky event flag.
module conditioner_channel
  import conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_async,
  input  logic [1:0] edge_mode,
  input  logic       event_clear,
  output logic       level_out,
  output logic       edge_pulse,
  output logic       event_flag
);

  localparam int unsigned   CW       = clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   flag_q, flag_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in_async};
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync;
        pulse_d = edge_qualifies(edge_mode, sync);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // A pending pulse sets the flag even when a clear arrives on the same edge.
    flag_d = pulse_q | (flag_q & ~event_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
    end
  end

  assign level_out  = level_q;
  assign edge_pulse = pulse_q;
  assign event_flag = flag_q;

endmodule

// File: rtl/conditioner_bank.sv
// Bank of independent input conditioners with a combined event indicator.
module conditioner_bank
  import conditioner_pkg::*;
#(
  parameter int unsigned CHANNELS      = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   input_async,
  input  logic [2*CHANNELS-1:0] edge_mode,
  input  logic [CHANNELS-1:0]   event_clear,
  output logic [CHANNELS-1:0]   level_out,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   event_flags,
  output logic                  any_event
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    conditioner_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .in_async   (input_async[i]),
      .edge_mode  (edge_mode[2*i +: 2]),
      .event_clear(event_clear[i]),
      .level_out  (level_out[i]),
      .edge_pulse (edge_pulse[i]),
      .event_flag (event_flags[i])
    );
  end

  assign any_event = |event_flags;

endmodule

// File: tb/tb_conditioner_bank.sv
// Scoreboard bench for conditioner_bank: default instance with directed
// scenarios, plus a fast (3-stage, no-filter) instance driven randomly.
module tb_conditioner_bank;
  import conditioner_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_a, clr_a, lvl_a, pls_a, flg_a;
  logic [15:0] mode_a;
  logic        any_a;
  logic [7:0]  in_b, clr_b, lvl_b, pls_b, flg_b;
  logic [15:0] mode_b;
  logic        any_b;

  always #5 clk = ~clk;

  conditioner_bank dut_a (
    .clk(clk), .reset(reset), .input_async(in_a), .edge_mode(mode_a),
    .event_clear(clr_a), .level_out(lvl_a), .edge_pulse(pls_a),
    .event_flags(flg_a), .any_event(any_a)
  );

  conditioner_bank #(.CHANNELS(8), .SYNC_STAGES(3), .FILTER_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .input_async(in_b), .edge_mode(mode_b),
    .event_clear(clr_b), .level_out(lvl_b), .edge_pulse(pls_b),
    .event_flags(flg_b), .any_event(any_b)
  );

  // kind 0: dut_a channel {level,pulse,flag}; 1: dut_a any_event;
  // 2: whole dut_a output set; 3: whole dut_b output set.
  typedef struct {
    int          cyc;
    int          kind;
    int          ch;
    logic [31:0] val;
    logic [31:0] mask;
    string       name;
  } exp_t;

  localparam logic [2:0] L = 3'b100, P = 3'b010, F = 3'b001, ALL = 3'b111;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, int k, int ch, logic [31:0] v, logic [31:0] m, string nm);
    exp_t e;
    e = '{c, k, ch, v, m, nm};
    sb.push_back(e);
  endfunction

  function automatic void expect_ch(int c, int ch, logic [2:0] m, logic [2:0] v, string nm);
    push(c, 0, ch, {29'd0, v}, {29'd0, m}, nm);
  endfunction

  function automatic logic [31:0] actual(int k, int ch);
    case (k)
      0:       return {29'd0, lvl_a[ch], pls_a[ch], flg_a[ch]};
      1:       return {31'd0, any_a};
      2:       return {7'd0, any_a, flg_a, pls_a, lvl_a};
      default: return {7'd0, any_b, flg_b, pls_b, lvl_b};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [31:0] act;
        act = actual(sb[i].kind, sb[i].ch);
        n_tests++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s ch%0d: expectation for cycle %0d missed (now %0d)",
                   sb[i].name, sb[i].ch, sb[i].cyc, cyc);
        end else if ((act & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
          n_fail++;
          $display("FAIL %s ch%0d @cycle %0d: got %h, expected %h (mask %h)",
                   sb[i].name, sb[i].ch, cyc, act & sb[i].mask,
                   sb[i].val & sb[i].mask, sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n, m, c;
    logic [7:0] hist[$];
    logic [7:0] lvl_m, pls_m, flg_m, new_lvl, new_pls, new_flg;
    logic [1:0] md;
    logic       rising, q;

    reset = 1'b1;
    in_a = '0; clr_a = '0; mode_a = '0;
    in_b = '0; clr_b = '0;
    mode_a[1:0] = EDGE_RISE;
    mode_a[3:2] = EDGE_BOTH;
    mode_a[7:6] = EDGE_BOTH;
    mode_a[9:8] = EDGE_RISE;
    mode_b = 16'hE4E4;   // per channel: none, rise, fall, both (repeated)

    tick(3);
    push(cyc + 1, 2, 0, '0, '1, "reset_state_a");
    push(cyc + 1, 3, 0, '0, '1, "reset_state_b");
    tick(1);
    reset = 1'b0;
    n = cyc;
    for (int i = 1; i <= 20; i++) push(n + i, 2, 0, '0, '1, "idle_zero");
    tick(20);

    // Clean rising step on ch0: 5-cycle latency, flag one cycle later.
    n = cyc;
    in_a[0] = 1'b1;
    expect_ch(n + 5, 0, ALL, 3'b000, "rise_not_early");
    expect_ch(n + 6, 0, ALL, 3'b110, "rise_pulse");
    expect_ch(n + 7, 0, ALL, 3'b101, "rise_flag");
    push(n + 6, 1, 0, 32'd0, 32'd1, "any_before_flag");
    push(n + 7, 1, 0, 32'd1, 32'd1, "any_after_flag");
    tick(12);

    // 3-cycle glitch on ch1 is discarded.
    n = cyc;
    for (int i = 1; i <= 15; i++) expect_ch(n + i, 1, ALL, 3'b000, "glitch3");
    in_a[1] = 1'b1;
    tick(3);
    in_a[1] = 1'b0;
    tick(15);

    // 4-cycle pulse on ch1 survives: rise then fall pulse.
    n = cyc;
    expect_ch(n + 5,  1, ALL, 3'b000, "g4_pre");
    expect_ch(n + 6,  1, ALL, 3'b110, "g4_rise");
    expect_ch(n + 7,  1, ALL, 3'b101, "g4_rise_end");
    expect_ch(n + 9,  1, ALL, 3'b101, "g4_hold");
    expect_ch(n + 10, 1, ALL, 3'b011, "g4_fall");
    expect_ch(n + 11, 1, ALL, 3'b001, "g4_fall_end");
    in_a[1] = 1'b1;
    tick(4);
    in_a[1] = 1'b0;
    tick(15);

    // Mode matrix on ch2: period-20 square wave, 4 periods per mode.
    for (int mi = 0; mi < 4; mi++) begin
      md = 2'(mi);
      mode_a[5:4] = md;
      n = cyc;
      expect_ch(n + 2, 2, P, 3'b000, "mode_change_quiet");
      for (int p = 0; p < 8; p++) begin
        rising = (p % 2 == 0);
        q = (md == EDGE_BOTH) || (md == EDGE_RISE && rising) || (md == EDGE_FALL && !rising);
        expect_ch(n + 10*p + 6, 2, P, q ? P : 3'b000, "mode_pulse");
        expect_ch(n + 10*p + 7, 2, P, 3'b000, "mode_pulse_end");
        expect_ch(n + 10*p + 6, 2, L, rising ? L : 3'b000, "mode_level");
      end
      for (int p = 0; p < 8; p++) begin
        in_a[2] = (p % 2 == 0);
        tick(10);
      end
    end

    // Clear the flags left by ch0..ch2.
    n = cyc;
    expect_ch(n, 1, F, F, "flag1_before_clear");
    push(n + 1, 1, 0, 32'd0, 32'd1, "any_clear_all");
    expect_ch(n + 1, 0, F, 3'b000, "flag0_cleared");
    expect_ch(n + 1, 2, F, 3'b000, "flag2_cleared");
    clr_a = 8'h07;
    tick(1);
    clr_a = '0;
    tick(3);

    // Clear on the same edge as the flag sets: set wins.
    n = cyc;
    expect_ch(n + 6, 3, ALL, 3'b110, "c3_pulse");
    expect_ch(n + 7, 3, F, F, "set_wins");
    push(n + 7, 1, 0, 32'd1, 32'd1, "any_set_wins");
    in_a[3] = 1'b1;
    tick(6);
    clr_a[3] = 1'b1;
    tick(1);
    clr_a[3] = 1'b0;
    tick(4);
    m = cyc;
    expect_ch(m,     3, F, F, "flag_held");
    expect_ch(m + 1, 3, F, 3'b000, "late_clear");
    push(m + 1, 1, 0, 32'd0, 32'd1, "any_drop");
    expect_ch(m + 2, 3, ALL, 3'b100, "clear_zero_noop");
    clr_a[3] = 1'b1;
    tick(2);
    clr_a[3] = 1'b0;
    tick(3);

    // Reset during debounce on ch4 (cnt=2), then full latency again.
    n = cyc;
    push(n + 5, 2, 0, '0, '1, "reset_mid_debounce_a");
    push(n + 5, 3, 0, '0, '1, "reset_mid_debounce_b");
    for (int i = 6; i <= 10; i++) expect_ch(n + i, 4, L | P, 3'b000, "no_early_rise");
    expect_ch(n + 11, 4, ALL, 3'b110, "rise_after_reset");
    expect_ch(n + 12, 4, ALL, 3'b101, "flag_after_reset");
    in_a[4] = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(12);

    // Fast instance: level_out is the input delayed by 3 cycles.
    lvl_m = '0; pls_m = '0; flg_m = '0;
    hist = '{8'h00, 8'h00, 8'h00};
    for (int t = 0; t < 200; t++) begin
      in_b  = 8'($urandom);
      clr_b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      hist.push_back(in_b);
      c = cyc;
      new_lvl = hist[hist.size() - 4];
      for (int ch = 0; ch < 8; ch++) begin
        md = mode_b[2*ch +: 2];
        new_pls[ch] = (new_lvl[ch] != lvl_m[ch]) && (new_lvl[ch] ? md[0] : md[1]);
      end
      new_flg = pls_m | (flg_m & ~clr_b);
      push(c + 1, 3, 0, {7'd0, |new_flg, new_flg, new_pls, new_lvl}, '1, "sweep");
      lvl_m = new_lvl; pls_m = new_pls; flg_m = new_flg;
      tick(1);
    end
    in_b = '0;
    clr_b = '0;

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    if (sb.size() != 0) begin
      n_tests += sb.size();
      n_fail  += sb.size();
      $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
